// File: rtl/apb_ram_ctrl_if.sv
// APB3 slave bus bundle for apb_ram_ctrl: 5-bit byte address, 32-bit data.
interface apb_ram_ctrl_if;
  logic [4:0]  paddr;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output paddr, pwrite, psel, penable, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pwrite, psel, penable, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_ram_ctrl.sv
// APB pointer/data window onto a single-port RAM, plus a hardware fill engine.
// Define RAMCTRL_FILL_INC_EN for an incrementing fill pattern (FILLVAL + address).
module apb_ram_ctrl #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  apb_ram_ctrl_if.slave         apb,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  irq
);

  typedef enum logic {IDLE, FILL} state_t;

  localparam logic [2:0] REG_PTR    = 3'd0;
  localparam logic [2:0] REG_DATA   = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_FILL   = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] fillval;
  logic                  ainc;
  logic                  irq_en;
  logic                  done;

  logic                  busy;
  logic                  access;
  logic [2:0]            reg_idx;
  logic                  sel_data;
  logic                  addr_ok;
  logic                  ptr_err;
  logic                  ready;
  logic                  xfer;
  logic                  wr_xfer;
  logic [ADDR_WIDTH-1:0] ptr_next;
  logic [DATA_WIDTH-1:0] fill_word;
  logic [31:0]           rdata;
  logic                  unused_paddr;

  assign busy     = (state == FILL);
  assign access   = apb.psel & apb.penable;
  assign reg_idx  = apb.paddr[4:2];
  assign sel_data = (reg_idx == REG_DATA);
  assign addr_ok  = (reg_idx <= REG_STATUS);
  assign ptr_err  = (reg_idx == REG_PTR) & apb.pwrite & (apb.pwdata >= 32'(DEPTH));
  // Only DATA needs the RAM port, so only DATA stalls while the fill engine owns it.
  assign ready    = ~(access & sel_data & busy);
  assign xfer     = access & ready;
  assign wr_xfer  = xfer & apb.pwrite & addr_ok & ~ptr_err;
  assign ptr_next = (ptr == LAST) ? '0 : ptr + 1'b1;
  assign unused_paddr = ^apb.paddr[1:0];

`ifdef RAMCTRL_FILL_INC_EN
  assign fill_word = fillval + DATA_WIDTH'(cnt);
`else
  assign fill_word = fillval;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      fillval <= '0;
      ainc    <= 1'b0;
      irq_en  <= 1'b0;
      done    <= 1'b0;
    end else begin
      if (wr_xfer) begin
        case (reg_idx)
          REG_PTR:    ptr     <= apb.pwdata[ADDR_WIDTH-1:0];
          REG_CTRL:   begin
                        ainc   <= apb.pwdata[0];
                        irq_en <= apb.pwdata[2];
                      end
          REG_FILL:   fillval <= apb.pwdata[DATA_WIDTH-1:0];
          REG_STATUS: if (apb.pwdata[1]) done <= 1'b0;
          default:    ;
        endcase
      end
      if (xfer && sel_data && ainc) ptr <= ptr_next;

      // Placed after the register writes so a fill completion beats a same-edge DONE clear.
      case (state)
        IDLE: if (wr_xfer && reg_idx == REG_CTRL && apb.pwdata[1]) begin
          state <= FILL;
          cnt   <= '0;
        end
        FILL: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ram_addr  = ptr;
    ram_wdata = '0;
    ram_we    = 1'b0;
    if (busy) begin
      ram_addr  = cnt;
      ram_wdata = fill_word;
      ram_we    = 1'b1;
    end else if (xfer && apb.pwrite && sel_data) begin
      ram_wdata = apb.pwdata[DATA_WIDTH-1:0];
      ram_we    = 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    if (xfer && !apb.pwrite) begin
      case (reg_idx)
        REG_PTR:    rdata = 32'(ptr);
        REG_DATA:   rdata = 32'(ram_rdata);
        REG_CTRL:   rdata = {29'd0, irq_en, 1'b0, ainc};
        REG_FILL:   rdata = 32'(fillval);
        REG_STATUS: rdata = {30'd0, done, busy};
        default:    rdata = '0;
      endcase
    end
  end

  assign apb.prdata  = rdata;
  assign apb.pready  = ready;
  assign apb.pslverr = access & (~addr_ok | ptr_err);
  assign irq         = done & irq_en;

endmodule

// File: doc/apb_ram_ctrl.md
# apb_ram_ctrl

APB slave that owns the single port of the `ram` block and gives software indirect access to it through a pointer/data register window. It also runs a hardware fill engine that writes all `DEPTH` words without CPU involvement. It sits directly upstream of `ram`: its `ram_*` outputs drive `addr`, `i_data` and `we`, and its `ram_rdata` input takes `o_data`.

## Interface
- `ADDR_WIDTH`, 4, RAM address width; must match `ram`.
- `DATA_WIDTH`, 8, RAM word width, ≤ 32; must match `ram`.
- `DEPTH`, 16, number of RAM words, 2 ≤ DEPTH ≤ 2^ADDR_WIDTH.

- `clk` input 1: the single clock; all logic on its rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `paddr` input 5: APB byte address.
- `pwrite` input 1: APB write.
- `psel` input 1: APB select.
- `penable` input 1: APB access phase.
- `pwdata` input 32: APB write data.
- `prdata` output 32: APB read data.
- `pready` output 1: APB ready.
- `pslverr` output 1: APB error.
- `ram_addr` output ADDR_WIDTH: to `ram.addr`.
- `ram_wdata` output DATA_WIDTH: to `ram.i_data`.
- `ram_we` output 1: to `ram.we`.
- `ram_rdata` input DATA_WIDTH: from `ram.o_data`, combinational read.
- `irq` output 1: fill-done interrupt, level.

## Operation
- Access phase: `psel & penable`. A transfer completes on the edge where the access phase and `pready` are both high.
- Register map (byte offsets):
  - 0x00 PTR: `[ADDR_WIDTH-1:0]`, read/write. A write of `pwdata ≥ DEPTH` returns `pslverr=1` and leaves PTR unchanged.
  - 0x04 DATA:
    - Write: `mem[PTR] ← pwdata[DATA_WIDTH-1:0]`.
    - Read: returns `ram_rdata` zero-extended.
    - Either access advances PTR by 1 if AINC is set.
  - 0x08 CTRL: bit0 AINC, bit1 START (write-1 pulse, reads 0), bit2 IRQ_EN.
  - 0x0C FILLVAL: `[DATA_WIDTH-1:0]`, read/write.
  - 0x10 STATUS: bit0 BUSY (read-only), bit1 DONE (write-1-to-clear).
  - Any other `paddr`: `pslverr=1`, no side effects, `prdata=0`.
- Unused read bits return 0. `paddr[1:0]` is ignored.
- PTR wraps from `DEPTH-1` to 0.
- FSM states: IDLE and FILL.
  - IDLE → FILL on a completed CTRL write with bit1=1. Fill counter ← 0, BUSY ← 1.
  - FILL: each cycle drives `ram_we=1`, `ram_addr=cnt`, `ram_wdata=fill word`, then increments cnt.
  - FILL → IDLE on the cycle where `cnt==DEPTH-1`. BUSY ← 0, DONE ← 1.
  - START while in FILL is ignored.
- Port ownership:
  - In FILL the engine owns the `ram_*` outputs.
  - In IDLE, `ram_addr=PTR`. `ram_we` and `ram_wdata` are driven by a DATA write in its access phase.
- `irq = DONE & IDLE_EN` is wrong; the required equation is `irq = DONE & IRQ_EN`, a registered-source level output.

## Timing
- Reset values:
  - Registers: PTR, CTRL, FILLVAL, DONE and BUSY all 0; state IDLE.
  - Outputs: `prdata=0`, `pready=1`, `pslverr=0`, `ram_we=0`, `ram_addr=0`, `ram_wdata=0`, `irq=0`.
- Register accesses: zero wait states. `prdata` and `pslverr` are valid during the access phase and are 0 outside it.
- DATA read: `ram_rdata` is combinational from `ram_addr=PTR`, so data is valid in the same access cycle.
- DATA write: `ram_we` is high for exactly the completing access cycle, and the RAM captures on that edge.
- DATA access while BUSY: `pready=0` until the cycle after FILL exits. The access then completes against the PTR value at that time.
- Accesses to non-DATA registers during FILL complete with zero wait states. A PTR write during FILL is legal.
- Fill latency: START completes on edge E0. Writes to addresses 0..DEPTH-1 occur on edges E1..E_DEPTH. BUSY=0 and DONE=1 are visible after E_DEPTH.
- Simultaneous DONE set and DONE W1C on the same edge: set wins.
- Reset asserted mid-fill: the fill aborts with DONE=0, and RAM contents are partially written and undefined.

## Configuration
- `RAMCTRL_FILL_INC_EN` defined: fill word = `FILLVAL + cnt`, modulo 2^DATA_WIDTH (incrementing pattern).
- `RAMCTRL_FILL_INC_EN` undefined: fill word = FILLVAL for every address (constant fill). The adder is not compiled.

## Test plan
- Reset, then read every register → all return 0. Check `pready=1`, `irq=0`, `ram_we=0`.
- AINC=1, PTR=0xE, write DATA 0xA1, 0xB2, 0xC3 → mem[14]=0xA1, mem[15]=0xB2, mem[0]=0xC3; PTR reads 1.
- FILLVAL=0x40, IRQ_EN=1, START → `ram_we` high for exactly 16 cycles.
  - Constant build: all words read 0x40.
  - Incrementing build: words read 0x40..0x4F.
  - After completion: DONE=1, `irq=1`; W1C of STATUS bit1 → `irq=0`.
- DATA read issued 2 cycles after START → `pready` low until the cycle after FILL exits, then returns the filled word at PTR.
- Write PTR=16 with DEPTH=16, and access `paddr=0x14` → `pslverr=1`, PTR unchanged, no RAM write.
- Assert `rst_n` low at fill cycle 5 → BUSY=0 and DONE=0 after release. A new START completes a full fill normally.
